// File: rtl/lstm_act_reader_if.sv
// -----------------------------------------------------------------------------
// lstm_act_reader_if
//
// Purpose:
//   Bundles the command, memory-read and output-stream signals of the LSTM
//   activation reader. Clock and reset stay outside as plain ports.
//
// Signals (direction as seen from the reader, i.e. the master modport):
//   start     in   1       one-cycle command pulse
//   step_sel  in   3       timestep to stream
//   busy      out  1       high from accepted start until done
//   done      out  1       one-cycle pulse after last word accepted
//   cmd_err   out  1       one-cycle pulse when a start is rejected
//   ram_addr  out  ADDR_W  read address to memory port B
//   ram_dout  in   DATA_W  memory port B data, one cycle after ram_addr
//   out_data  out  DATA_W  streamed activation
//   out_valid out  1       out_data valid
//   out_ready in   1       downstream accept
//   out_last  out  1       final word of the timestep
//   out_idx   out  6       unit index of out_data
// -----------------------------------------------------------------------------
interface lstm_act_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);

  logic              start;
  logic [2:0]        step_sel;
  logic              busy;
  logic              done;
  logic              cmd_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [5:0]        out_idx;

  // The reader side: drives status, memory address and the output stream.
  modport master (
    input  start, step_sel, ram_dout, out_ready,
    output busy, done, cmd_err, ram_addr, out_data, out_valid, out_last, out_idx
  );

  // The environment side: issues commands, returns memory data, consumes words.
  modport slave (
    output start, step_sel, ram_dout, out_ready,
    input  busy, done, cmd_err, ram_addr, out_data, out_valid, out_last, out_idx
  );

endinterface

// File: rtl/lstm_act_reader.sv
// -----------------------------------------------------------------------------
// lstm_act_reader
//
// Purpose:
//   Read sequencer for port B of the LSTM activation memory. On a start
//   command it streams the N_UNITS words of one timestep (address
//   step*N_UNITS + unit) to the downstream MAC/gate stage over valid/ready.
//   The one-cycle memory read latency is hidden by issuing reads ahead, and
//   downstream backpressure is absorbed by a 2-entry output buffer so the
//   stream runs at one word per cycle when out_ready is held high.
//
// Ports:
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   rev    in  1   (only with LSTM_ACT_REVERSE_EN) stream units high to low,
//                  sampled together with start
//   bus    lstm_act_reader_if.master: start/step_sel command, busy/done/
//          cmd_err status, ram_addr/ram_dout memory port, out_* stream
//
// Configuration:
//   LSTM_ACT_REVERSE_EN  when defined, adds the rev port for the backward
//                        pass. When undefined, forward order only.
// -----------------------------------------------------------------------------
module lstm_act_reader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int N_UNITS = 53,
  parameter int N_STEPS = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef LSTM_ACT_REVERSE_EN
  input  logic rev,
`endif
  lstm_act_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [5:0] LAST_UNIT = 6'(N_UNITS - 1);

  state_t state, state_next;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [5:0]        issue_cnt;
  logic              rev_q;
  logic              rev_in;

  logic              inflight;
  logic [5:0]        inflight_idx;

  logic [DATA_W-1:0] buf_data [2];
  logic [5:0]        buf_idx  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              done_q;
  logic              cmd_err_q;

  logic              accept;
  logic              issue;
  logic              finish;
  logic              pop;
  logic              out_valid;
  logic [2:0]        occupancy;
  logic [5:0]        cur_idx;
  logic [5:0]        next_idx;
  logic [5:0]        first_idx;
  logic [5:0]        last_idx;

  // The direction request only exists in the reverse-capable build; the
  // forward-only build ties it off so the rest of the logic is shared.
`ifdef LSTM_ACT_REVERSE_EN
  assign rev_in = rev;
`else
  assign rev_in = 1'b0;
`endif

  // Base address of the requested timestep, computed at full address width.
  // With the default sizes the largest address is 423, so 9 bits never wrap.
  assign start_base = ADDR_W'(bus.step_sel) * ADDR_W'(N_UNITS);

  // Unit index of the read about to issue, and the one after it. In reverse
  // order the issue counter still counts up; only the index mapping flips.
  assign cur_idx   = rev_q  ? (LAST_UNIT - issue_cnt) : issue_cnt;
  assign next_idx  = rev_q  ? (cur_idx - 6'd1) : (cur_idx + 6'd1);
  assign first_idx = rev_in ? LAST_UNIT : 6'd0;
  assign last_idx  = rev_q  ? 6'd0 : LAST_UNIT;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & bus.out_ready;

  // Slots that will be occupied at the end of this cycle if nothing new
  // issues: buffered words plus the read in flight, minus a word leaving
  // now. Counting the pop lets a read issue in the same cycle a word leaves,
  // which is what keeps the stream at one word per cycle; the buffer still
  // never holds more than two entries.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);

  // Next-state and control decode. accept/issue/finish are single-cycle
  // strobes consumed by the datapath register block below.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && ({29'd0, bus.step_sel} < 32'(N_STEPS))) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (issue_cnt == LAST_UNIT) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Returning to IDLE on the same edge that raises done
  // makes busy fall in the very cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command latch, read issue and status pulses. ram_addr is kept equal to
  // base + index of the next read so the memory sees the right address in
  // the issue cycle; after the final issue it simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      issue_cnt    <= '0;
      rev_q        <= 1'b0;
      ram_addr_q   <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      cmd_err_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cmd_err_q <= bus.start & ~accept;
      done_q    <= finish;
      inflight  <= issue;
      if (accept) begin
        base_q     <= start_base;
        issue_cnt  <= '0;
        rev_q      <= rev_in;
        ram_addr_q <= start_base + ADDR_W'(first_idx);
      end
      if (issue) begin
        inflight_idx <= cur_idx;
        if (issue_cnt != LAST_UNIT) begin
          issue_cnt  <= issue_cnt + 6'd1;
          ram_addr_q <= base_q + ADDR_W'(next_idx);
        end
      end
    end
  end

  // Two-entry output FIFO. The word returned by the memory is written at the
  // tail together with the unit index that travelled alongside the read.
  // A capture and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_idx[0]  <= '0;
      buf_idx[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (inflight) begin
        buf_data[wr_ptr] <= bus.ram_dout;
        buf_idx[wr_ptr]  <= inflight_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(inflight) - 2'(pop);
    end
  end

  // The head entry only changes on a pop, so out_data is stable while the
  // downstream stage stalls.
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.out_data  = buf_data[rd_ptr];
  assign bus.out_idx   = buf_idx[rd_ptr];
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_valid && (buf_idx[rd_ptr] == last_idx);

endmodule
